// File: rtl/scp_079_gen.sv
// SCP-079 staged intrusion sequencer.
// Green advances the stages, yellow stalls them, red forces containment.
module scp_079_gen #(
  parameter int T_SEC     = 10,
  parameter int T_DB      = 10,
  parameter int T_CTRL    = 10,
  parameter int T_RED     = 3,
  parameter int T_CONTAIN = 5,
  parameter int TIMER_W   = 8
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               green,
  input  logic               yellow,
  input  logic               red,
  output logic               a_security,
  output logic               a_database,
  output logic               a_control_sys,
  output logic               cheat_out,
  output logic [2:0]         state,
  output logic [TIMER_W-1:0] timer,
  output logic               alarm_err
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SEC     = 3'd1,
    DB      = 3'd2,
    CTRL    = 3'd3,
    CHEAT   = 3'd4,
    CONTAIN = 3'd5
  } st_t;

  typedef logic [TIMER_W-1:0] tmr_t;

  localparam tmr_t SEC_END = tmr_t'(T_SEC - 1);
  localparam tmr_t DB_END  = tmr_t'(T_DB - 1);
  localparam tmr_t CTL_END = tmr_t'(T_CTRL - 1);
  localparam tmr_t RED_END = tmr_t'(T_RED - 1);
  localparam tmr_t CON_END = tmr_t'(T_CONTAIN - 1);
  localparam tmr_t TMAX    = '1;

  logic onehot;
  logic go_r;
  logic go_y;

  st_t  st;
  st_t  st_n;
  tmr_t tm;
  tmr_t tm_n;
  tmr_t stage_end;

  function automatic tmr_t inc(input tmr_t t);
    return (t == TMAX) ? t : t + tmr_t'(1);
  endfunction

  // Any non-one-hot code fails safe to red.
  assign onehot = $onehot({green, yellow, red});
  assign go_r   = red | ~onehot;
  assign go_y   = onehot & yellow;

  always_comb begin
    stage_end = SEC_END;
    case (st)
      DB:      stage_end = DB_END;
      CTRL:    stage_end = CTL_END;
      default: stage_end = SEC_END;
    endcase
  end

  always_comb begin
    st_n = st;
    tm_n = tm;
    case (st)
      IDLE: begin
        if (!go_r && !go_y) begin
          st_n = SEC;
          tm_n = '0;
        end
      end
      SEC, DB, CTRL: begin
        unique case (1'b1)
          go_r: begin
            st_n = CONTAIN;
            tm_n = '0;
          end
          go_y: begin
            st_n = st;
          end
          default: begin
            if (tm == stage_end) begin
              st_n = st_t'(st + 3'd1);
              tm_n = '0;
            end else begin
              tm_n = inc(tm);
            end
          end
        endcase
      end
      CHEAT: begin
        if (!go_r) begin
          tm_n = '0;
        end else if (tm == RED_END) begin
          st_n = CONTAIN;
          tm_n = '0;
        end else begin
          tm_n = inc(tm);
        end
      end
      CONTAIN: begin
        if (tm == CON_END && !go_r) begin
          st_n = IDLE;
          tm_n = '0;
        end else if (tm != CON_END) begin
          tm_n = inc(tm);
        end
      end
      default: begin
        st_n = CONTAIN;
        tm_n = '0;
      end
    endcase
  end

  // Flags are decoded from the next state so they register with it.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      st            <= IDLE;
      tm            <= '0;
      alarm_err     <= 1'b0;
      a_security    <= 1'b0;
      a_database    <= 1'b0;
      a_control_sys <= 1'b0;
      cheat_out     <= 1'b0;
    end else begin
      st            <= st_n;
      tm            <= tm_n;
      alarm_err     <= ~onehot;
      a_security    <= st_n inside {SEC, DB, CTRL, CHEAT};
      a_database    <= st_n inside {DB, CTRL, CHEAT};
      a_control_sys <= st_n inside {CTRL, CHEAT};
      cheat_out     <= (st_n == CHEAT);
    end
  end

  assign state = st;
  assign timer = tm;

endmodule

// File: tb/tb_scp_079_gen.sv
// Bench for scp_079_gen: directed scenarios plus random alerts
// checked against a behavioural sequencer model.
module tb_scp_079_gen;

  localparam int TS   = 4;
  localparam int TDB  = 4;
  localparam int TCT  = 4;
  localparam int TRED = 3;
  localparam int TCON = 5;
  localparam int TW   = 4;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          green;
  logic          yellow;
  logic          red;
  logic          a_security;
  logic          a_database;
  logic          a_control_sys;
  logic          cheat_out;
  logic [2:0]    state;
  logic [TW-1:0] timer;
  logic          alarm_err;

  int checks = 0;
  int errors = 0;

  int m_st  = 0;
  int m_tm  = 0;
  int m_err = 0;
  int dwell [4] = '{0, TS, TDB, TCT};

  scp_079_gen #(
    .T_SEC(TS), .T_DB(TDB), .T_CTRL(TCT),
    .T_RED(TRED), .T_CONTAIN(TCON), .TIMER_W(TW)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .green(green), .yellow(yellow), .red(red),
    .a_security(a_security), .a_database(a_database),
    .a_control_sys(a_control_sys), .cheat_out(cheat_out),
    .state(state), .timer(timer), .alarm_err(alarm_err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: stage S needs dwell[S] green cycles, CHEAT falls
  // after TRED reds in a row, CONTAIN lasts at least TCON cycles.
  task automatic model(input logic g, input logic y, input logic r);
    bit valid;
    bit rr;
    bit yy;
    valid = (int'(g) + int'(y) + int'(r)) == 1;
    m_err = valid ? 0 : 1;
    rr = r || !valid;
    yy = valid && y;
    if (m_st == 0) begin
      if (!rr && !yy) begin m_st = 1; m_tm = 0; end
    end else if (m_st <= 3) begin
      if (rr) begin
        m_st = 5; m_tm = 0;
      end else if (!yy) begin
        if (m_tm + 1 >= dwell[m_st]) begin
          m_st = m_st + 1; m_tm = 0;
        end else begin
          m_tm = m_tm + 1;
        end
      end
    end else if (m_st == 4) begin
      if (!rr) m_tm = 0;
      else if (m_tm + 1 >= TRED) begin m_st = 5; m_tm = 0; end
      else m_tm = m_tm + 1;
    end else begin
      if (m_tm == TCON - 1 && !rr) begin m_st = 0; m_tm = 0; end
      else if (m_tm < TCON - 1) m_tm = m_tm + 1;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".state"}, int'(state), m_st);
    chk({tag, ".timer"}, int'(timer), m_tm);
    chk({tag, ".err"}, int'(alarm_err), m_err);
    chk({tag, ".sec"}, int'(a_security), int'(m_st >= 1 && m_st <= 4));
    chk({tag, ".db"}, int'(a_database), int'(m_st >= 2 && m_st <= 4));
    chk({tag, ".ctl"}, int'(a_control_sys), int'(m_st == 3 || m_st == 4));
    chk({tag, ".cheat"}, int'(cheat_out), int'(m_st == 4));
  endtask

  task automatic step(input logic g, input logic y, input logic r,
                      input string tag);
    green  = g;
    yellow = y;
    red    = r;
    @(posedge clock);
    model(g, y, r);
    #1;
    check_all(tag);
  endtask

  task automatic steps(input int n, input logic g, input logic y,
                       input logic r, input string tag);
    for (int i = 0; i < n; i++) step(g, y, r, tag);
  endtask

  initial begin
    reset_n = 1'b0;
    green   = 1'b0;
    yellow  = 1'b0;
    red     = 1'b0;
    #12;
    chk("rst.state", int'(state), 0);
    chk("rst.timer", int'(timer), 0);
    chk("rst.flags", int'({a_security, a_database, a_control_sys,
                            cheat_out, alarm_err}), 0);
    reset_n = 1'b1;

    // Continuous green climbs to CHEAT on edge 13.
    step(1, 0, 0, "g1");
    chk("g1.sec", int'(state), 1);
    steps(3, 1, 0, 0, "gsec");
    step(1, 0, 0, "g5");
    chk("g5.db", int'(state), 2);
    steps(7, 1, 0, 0, "gdb");
    step(1, 0, 0, "g13");
    chk("g13.cheat", int'(cheat_out), 1);
    chk("g13.state", int'(state), 4);
    step(1, 0, 0, "g14");

    // CHEAT: red red green red red red.
    steps(2, 0, 0, 1, "ch_r");
    step(1, 0, 0, "ch_g");
    chk("ch_g.cheat", int'(cheat_out), 1);
    steps(2, 0, 0, 1, "ch_r2");
    chk("ch_r2.state", int'(state), 4);
    step(0, 0, 1, "ch_r3");
    chk("ch_r3.contain", int'(state), 5);

    // Leave CONTAIN, then stall DB at timer 2 with yellow.
    steps(5, 1, 0, 0, "con_g");
    chk("con_g.idle", int'(state), 0);
    steps(7, 1, 0, 0, "to_db");
    chk("to_db.timer", int'(timer), 2);
    steps(3, 0, 1, 0, "yel");
    chk("yel.hold", int'(timer), 2);
    step(1, 0, 0, "yg1");
    chk("yg1.db", int'(state), 2);
    step(1, 0, 0, "yg2");
    chk("yg2.ctrl", int'(state), 3);

    // Illegal code in CTRL is treated as red.
    step(1, 1, 0, "bad");
    chk("bad.err", int'(alarm_err), 1);
    chk("bad.state", int'(state), 5);
    steps(4, 1, 0, 0, "bad_g");
    chk("bad_g.err", int'(alarm_err), 0);
    step(1, 0, 0, "bad_idle");

    // Red in SEC at timer 1, then long red in CONTAIN.
    steps(2, 1, 0, 0, "sec1");
    chk("sec1.timer", int'(timer), 1);
    step(0, 0, 1, "sred");
    chk("sred.state", int'(state), 5);
    chk("sred.flags", int'({a_security, a_database, a_control_sys,
                             cheat_out}), 0);
    steps(10, 0, 0, 1, "hold");
    chk("hold.sat", int'(timer), 4);
    chk("hold.state", int'(state), 5);
    step(1, 0, 0, "rel1");
    chk("rel1.idle", int'(state), 0);
    step(1, 0, 0, "rel2");
    chk("rel2.sec", int'(state), 1);

    // Asynchronous reset in CTRL.
    steps(8, 1, 0, 0, "to_ctl");
    chk("to_ctl.state", int'(state), 3);
    #2 reset_n = 1'b0;
    #1;
    m_st = 0; m_tm = 0; m_err = 0;
    chk("arst.state", int'(state), 0);
    chk("arst.flags", int'({a_security, a_database, a_control_sys,
                             cheat_out, alarm_err}), 0);
    check_all("arst");
    #2 reset_n = 1'b1;
    step(1, 0, 0, "rs1");
    chk("rs1.sec", int'(state), 1);

    // Random alert codes, biased towards green.
    for (int i = 0; i < 600; i++) begin
      int p;
      logic [2:0] c;
      p = int'($urandom_range(0, 99));
      if (p < 70) c = 3'b100;
      else if (p < 82) c = 3'b010;
      else if (p < 94) c = 3'b001;
      else c = 3'($urandom_range(0, 7));
      step(c[2], c[1], c[0], "rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
